mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameters: none; opcodes and state encodings are package constants.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 opcode  in  6  instruction bits [31:26] from IR, sampled in DECODE.
REQ-005 mem_ready  in  1  memory handshake; access completes in the cycle it is 1.
REQ-006 pc_write, pc_write_cond  out  1 each  unconditional and zero-qualified PC write enables.
REQ-007 i_or_d  out  1  memory address select (0 = PC, 1 = ALUOut).
REQ-008 mem_read, mem_write  out  1 each  memory strobes.
REQ-009 ir_write, mem_to_reg, reg_write, reg_dst  out  1 each  IR/register-file controls.
REQ-010 pc_source  out  2  PC mux (00 ALU, 01 ALUOut, 10 jump target).
REQ-011 alu_op1, alu_op0  out  1 each  drive the ALU-control inputs (00 add, 01 sub, 10 funct).
REQ-012 alu_src_a  out  1; alu_src_b  out  2  ALU operand selects.
REQ-013 illegal_op  out  1  sticky unsupported-opcode flag.
REQ-014 state  out  4  current FSM state, for debug.

Function
REQ-015 Moore FSM; every output SHALL decode from the current state and mem_ready only. Unlisted outputs SHALL be 0.
REQ-016 States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, JUMP, plus ADDI_EX and ADDI_WB when configured.
REQ-017 FETCH: mem_read=1, alu_src_b=01, ALU op 00. When mem_ready=1, ir_write=1, pc_write=1, and the FSM goes to DECODE. Otherwise it holds with no write strobes.
REQ-018 DECODE: alu_src_b=11, ALU op 00. Next state by opcode: 100011/101011 -> MEM_ADDR; 000000 -> EXECUTE; 000100 -> BRANCH; 000010 -> JUMP.
REQ-019 MEM_ADDR: alu_src_a=1, alu_src_b=10, op 00. Next is MEM_READ for LW and MEM_WRITE for SW; the opcode is held in an internal register latched in DECODE.
REQ-020 MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
REQ-021 MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready, then goes to FETCH.
REQ-022 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
REQ-023 EXECUTE: alu_src_a=1, alu_src_b=00, op 10; then R_WB (reg_write=1, reg_dst=1), then FETCH.
REQ-024 BRANCH: alu_src_a=1, op 01, pc_write_cond=1, pc_source=01; then FETCH.
REQ-025 JUMP: pc_write=1, pc_source=10; then FETCH.
REQ-026 Latency without waits (mem_ready always 1): LW 5, SW 4, R 4, BEQ 3, J 3 cycles.
REQ-027 An unsupported opcode in DECODE SHALL set illegal_op and return to FETCH. illegal_op stays set until rst; later legal instructions do not clear it.
REQ-028 mem_ready outside FETCH/MEM_READ/MEM_WRITE SHALL be ignored.

Reset
REQ-029 rst=1 at a clock edge SHALL force state=FETCH and illegal_op=0, and clear the latched opcode. It overrides any transition, including in-flight mem_ready.
REQ-030 During rst, outputs SHALL equal the FETCH decode with ir_write=pc_write=0.

Configuration
REQ-031 Macro MIPS_CTRL_ADDI_EN defined: opcode 001000 goes DECODE -> ADDI_EX (alu_src_a=1, alu_src_b=10, op 00) -> ADDI_WB (reg_write=1, reg_dst=0, mem_to_reg=0) -> FETCH.
REQ-032 Macro undefined: ADDI states are absent, and 001000 is illegal per REQ-027.

Structure
REQ-033 Package mips_ctrl_pkg SHALL hold the opcode constants, the state enum/encodings, and the ALU-op constants.
REQ-034 No sub-module; the next-state and output decode live in one module.

Verification
REQ-035 rst, then LW (100011) with mem_ready=1 -> state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH; reg_write=1 and mem_to_reg=1 only in MEM_WB.
REQ-036 SW with mem_ready=0 for 3 cycles in MEM_WRITE -> mem_write held 4 cycles, then FETCH.
REQ-037 R-type -> EXECUTE drives alu_op1=1 and alu_op0=0; BEQ drives alu_op0=1 and pc_write_cond=1.
REQ-038 Opcode 111111 -> illegal_op=1 and return to FETCH; flag persists through a following J; cleared only by rst.
REQ-039 rst asserted in MEM_READ -> next state FETCH, no reg_write pulse.
REQ-040 Opcode 001000 with and without MIPS_CTRL_ADDI_EN -> 4-cycle ADDI with reg_write in ADDI_WB, versus illegal_op=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, ALU-op codes,
// PC-source codes and the FSM state encoding. Honours MIPS_CTRL_ADDI_EN.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
`ifdef MIPS_CTRL_ADDI_EN
        , S_ADDI_EX = 4'd10,
        S_ADDI_WB   = 4'd11
`endif
    } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath (LW/SW/R-type/BEQ/J).
// Defining MIPS_CTRL_ADDI_EN adds the two-state ADDI path.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic [1:0] pc_source,
    output logic       alu_op1,
    output logic       alu_op0,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       illegal_q, illegal_d;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        illegal_d     = illegal_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                op_d      = opcode;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`endif
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Only LW and SW reach here, so the latched opcode picks the direction.
                state_d   = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = S_FETCH;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        // While reset is held the datapath sees a write-free FETCH decode.
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b1;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            pc_source     = PCSRC_ALU;
            alu_op        = ALU_ADD;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b01;
        end
    end

    assign alu_op1    = alu_op[1];
    assign alu_op0    = alu_op[0];
    assign illegal_op = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed instruction cases plus
// randomized instruction streams with random memory wait cycles.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_op1, alu_op0, alu_src_a;
    logic [1:0] pc_source, alu_src_b;
    logic       illegal_op;
    logic [3:0] state;

    int   total = 0;
    int   bad   = 0;
    logic exp_ill = 1'b0;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
        .pc_source(pc_source), .alu_op1(alu_op1), .alu_op0(alu_op0),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_write, reg_dst, pc_source, alu_op1, alu_op0, alu_src_a, alu_src_b}
    logic [16:0] ctrl_word;
    assign ctrl_word = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                        mem_to_reg, reg_write, reg_dst, pc_source, alu_op1, alu_op0,
                        alu_src_a, alu_src_b};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: return 1'b1;
`ifdef MIPS_CTRL_ADDI_EN
            OP_ADDI: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Expected control outputs for a state, straight from the per-state output table.
    function automatic logic [16:0] exp_ctrl(input state_t s, input logic rdy, input logic r);
        logic pw, pwc, iod, mr, mw, irw, m2r, rw, rd, op1, op0, sa;
        logic [1:0] psrc, sb;
        {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, op1, op0, sa} = '0;
        psrc = 2'b00;
        sb   = 2'b00;
        if (r) begin
            mr = 1'b1; sb = 2'b01;
        end else begin
            case (s)
                S_FETCH:     begin mr = 1'b1; sb = 2'b01; irw = rdy; pw = rdy; end
                S_DECODE:    sb = 2'b11;
                S_MEM_ADDR:  begin sa = 1'b1; sb = 2'b10; end
                S_MEM_READ:  begin mr = 1'b1; iod = 1'b1; end
                S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
                S_MEM_WRITE: begin mw = 1'b1; iod = 1'b1; end
                S_EXECUTE:   begin sa = 1'b1; op1 = 1'b1; end
                S_R_WB:      begin rw = 1'b1; rd = 1'b1; end
                S_BRANCH:    begin sa = 1'b1; op0 = 1'b1; pwc = 1'b1; psrc = 2'b01; end
                S_JUMP:      begin pw = 1'b1; psrc = 2'b10; end
`ifdef MIPS_CTRL_ADDI_EN
                S_ADDI_EX:   begin sa = 1'b1; sb = 2'b10; end
                S_ADDI_WB:   rw = 1'b1;
`endif
                default: ;
            endcase
        end
        return {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, psrc, op1, op0, sa, sb};
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock: drive inputs after the falling edge, check before the rising edge.
    task automatic drive_cycle(input state_t es, input logic r, input logic rdy, input logic [5:0] op);
        @(negedge clk);
        rst       = r;
        mem_ready = rdy;
        opcode    = op;
        #1;
        check_val({"state/", es.name()}, 32'(state), 32'(es));
        check_val({"ctrl/", es.name()}, 32'(ctrl_word), 32'(exp_ctrl(es, rdy, r)));
        check_val({"illegal_op/", es.name()}, 32'(illegal_op), 32'(exp_ill));
        if (r) exp_ill = 1'b0;
    endtask

    task automatic mem_phase(input state_t s, input int waits);
        for (int i = 0; i < waits; i++) drive_cycle(s, 1'b0, 1'b0, rnd_op());
        drive_cycle(s, 1'b0, 1'b1, rnd_op());
    endtask

    // Opcode is driven with garbage outside DECODE, so the FSM must rely on its latched copy.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        mem_phase(S_FETCH, fw);
        drive_cycle(S_DECODE, 1'b0, rnd_bit(), op);
        if (!is_legal(op)) begin
            exp_ill = 1'b1;
        end else begin
            case (op)
                OP_LW: begin
                    drive_cycle(S_MEM_ADDR, 1'b0, rnd_bit(), rnd_op());
                    mem_phase(S_MEM_READ, mw);
                    drive_cycle(S_MEM_WB, 1'b0, rnd_bit(), rnd_op());
                end
                OP_SW: begin
                    drive_cycle(S_MEM_ADDR, 1'b0, rnd_bit(), rnd_op());
                    mem_phase(S_MEM_WRITE, mw);
                end
                OP_RTYPE: begin
                    drive_cycle(S_EXECUTE, 1'b0, rnd_bit(), rnd_op());
                    drive_cycle(S_R_WB, 1'b0, rnd_bit(), rnd_op());
                end
                OP_BEQ: drive_cycle(S_BRANCH, 1'b0, rnd_bit(), rnd_op());
                OP_J:   drive_cycle(S_JUMP, 1'b0, rnd_bit(), rnd_op());
`ifdef MIPS_CTRL_ADDI_EN
                OP_ADDI: begin
                    drive_cycle(S_ADDI_EX, 1'b0, rnd_bit(), rnd_op());
                    drive_cycle(S_ADDI_WB, 1'b0, rnd_bit(), rnd_op());
                end
`endif
                default: ;
            endcase
        end
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 7))
            0: return OP_LW;
            1: return OP_SW;
            2: return OP_RTYPE;
            3: return OP_BEQ;
            4: return OP_J;
            5: return OP_ADDI;
            6: return 6'b111111;
            default: return rnd_op();
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        repeat (2) @(posedge clk);

        // Reset view: FETCH decode with no write strobes even when memory is ready.
        drive_cycle(S_FETCH, 1'b1, 1'b1, rnd_op());
        drive_cycle(S_FETCH, 1'b1, 1'b0, rnd_op());

        run_instr(OP_LW, 0, 0);
        run_instr(OP_SW, 0, 3);
        run_instr(OP_RTYPE, 1, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_LW, 2, 1);
        drive_cycle(S_FETCH, 1'b1, 1'b0, rnd_op());

        // Reset while waiting in MEM_READ with memory ready: no write-back follows.
        mem_phase(S_FETCH, 0);
        drive_cycle(S_DECODE, 1'b0, 1'b0, OP_LW);
        drive_cycle(S_MEM_ADDR, 1'b0, 1'b0, rnd_op());
        drive_cycle(S_MEM_READ, 1'b0, 1'b0, rnd_op());
        drive_cycle(S_MEM_READ, 1'b1, 1'b1, rnd_op());
        drive_cycle(S_FETCH, 1'b0, 1'b0, rnd_op());

        run_instr(OP_ADDI, 0, 0);
        run_instr(OP_SW, 1, 2);

        for (int n = 0; n < 300; n++) begin
            run_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) drive_cycle(S_FETCH, 1'b1, rnd_bit(), rnd_op());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
